// File: rtl/dma_bus_master.sv
// Single-channel longword block-copy DMA initiator for a 68030-style asynchronous bus.
// Owns the bus via BR/BG/BGACK, copies count longwords src -> dst, then releases.
module dma_bus_master #(
   parameter int unsigned TIMEOUT = 255,
   parameter logic [2:0]  FC_CODE = 3'b101
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [15:0] count,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        br,
   input  logic        bg,
   input  logic        bus_busy,
   output logic        bgack,
   output logic        bus_drive,
   output logic        data_drive,
   output logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        as,
   output logic        ds,
   output logic        rn_w,
   output logic [1:0]  siz,
   output logic [2:0]  fc,
   input  logic [1:0]  dsack,
   input  logic        berr
);

   // state     | meaning
   // S_IDLE    | waiting for start
   // S_REQ     | br asserted, waiting for bg with bus idle
   // S_GRANT   | bgack asserted, source address driven
   // S_RD_S    | read strobes asserted, waiting for termination
   // S_RD_E    | read strobes negated, waiting for dsack/berr release
   // S_WR_A    | write address/data setup clock
   // S_WR_S    | write strobes asserted, waiting for termination
   // S_WR_E    | write strobes negated, waiting for dsack/berr release
   // S_ABORT   | failed cycle, waiting for dsack/berr release
   // S_RELEASE | bus released, done pulse
   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_GRANT, S_RD_S, S_RD_E,
      S_WR_A, S_WR_S, S_WR_E, S_ABORT, S_RELEASE
   } state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

   state_t        state_q, state_nx;
   logic [31:0]   src_q, src_nx, dst_q, dst_nx;
   logic [15:0]   rem_q, rem_nx;
   logic [31:0]   hold_q, hold_nx;
   logic [TW-1:0] tmr_q, tmr_nx;
   logic [31:0]   addr_q, addr_nx, data_out_q, data_out_nx;
   logic          busy_q, busy_nx, done_q, done_nx, error_q, error_nx;
   logic          br_q, br_nx, bgack_q, bgack_nx, data_drive_q, data_drive_nx;
   logic          as_q, as_nx, ds_q, ds_nx, rn_w_q, rn_w_nx;

   logic          bg_s1, bg_s2, bus_busy_s1, bus_busy_s2, berr_s1, berr_s2;
   logic [1:0]    dsack_s1, dsack_s2;
   logic          ack_ok, ack_bad, quiet, tmr_tc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bg_s1       <= 1'b0;
         bg_s2       <= 1'b0;
         bus_busy_s1 <= 1'b0;
         bus_busy_s2 <= 1'b0;
         berr_s1     <= 1'b0;
         berr_s2     <= 1'b0;
         dsack_s1    <= 2'b00;
         dsack_s2    <= 2'b00;
      end else begin
         bg_s1       <= bg;
         bg_s2       <= bg_s1;
         bus_busy_s1 <= bus_busy;
         bus_busy_s2 <= bus_busy_s1;
         berr_s1     <= berr;
         berr_s2     <= berr_s1;
         dsack_s1    <= dsack;
         dsack_s2    <= dsack_s1;
      end
   end

   // berr overrides a simultaneous dsack; a single-bit dsack is a port-size mismatch
   assign ack_ok  = (dsack_s2 == 2'b11) && !berr_s2;
   assign ack_bad = berr_s2 || (dsack_s2 == 2'b01) || (dsack_s2 == 2'b10);
   assign quiet   = (dsack_s2 == 2'b00) && !berr_s2;
   assign tmr_tc  = (tmr_q == '0);

   always_comb begin
      state_nx      = state_q;
      src_nx        = src_q;
      dst_nx        = dst_q;
      rem_nx        = rem_q;
      hold_nx       = hold_q;
      tmr_nx        = tmr_q;
      addr_nx       = addr_q;
      data_out_nx   = data_out_q;
      busy_nx       = busy_q;
      done_nx       = 1'b0;
      error_nx      = error_q;
      br_nx         = br_q;
      bgack_nx      = bgack_q;
      data_drive_nx = data_drive_q;
      as_nx         = as_q;
      ds_nx         = ds_q;
      rn_w_nx       = rn_w_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               error_nx = 1'b0;
               if (count == 16'd0) begin
                  done_nx = 1'b1;
               end else begin
                  src_nx   = src_addr & ~32'h3;
                  dst_nx   = dst_addr & ~32'h3;
                  rem_nx   = count;
                  busy_nx  = 1'b1;
                  br_nx    = 1'b1;
                  state_nx = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (bg_s2 && !bus_busy_s2) begin
               br_nx    = 1'b0;
               bgack_nx = 1'b1;
               addr_nx  = src_q;
               state_nx = S_GRANT;
            end
         end
         S_GRANT: begin
            rn_w_nx  = 1'b1;
            as_nx    = 1'b1;
            ds_nx    = 1'b1;
            tmr_nx   = TMR_LOAD;
            state_nx = S_RD_S;
         end
         S_RD_S, S_WR_S: begin
            if (ack_bad || (!ack_ok && tmr_tc)) begin
               error_nx      = 1'b1;
               as_nx         = 1'b0;
               ds_nx         = 1'b0;
               data_drive_nx = 1'b0;
               state_nx      = S_ABORT;
            end else if (ack_ok) begin
               as_nx = 1'b0;
               ds_nx = 1'b0;
               if (state_q == S_RD_S) begin
                  hold_nx  = data_in;
                  state_nx = S_RD_E;
               end else begin
                  state_nx = S_WR_E;
               end
            end else begin
               tmr_nx = tmr_q - 1'b1;
            end
         end
         S_RD_E: begin
            if (quiet) begin
               addr_nx       = dst_q;
               rn_w_nx       = 1'b0;
               data_out_nx   = hold_q;
               data_drive_nx = 1'b1;
               state_nx      = S_WR_A;
            end
         end
         S_WR_A: begin
            as_nx    = 1'b1;
            ds_nx    = 1'b1;
            tmr_nx   = TMR_LOAD;
            state_nx = S_WR_S;
         end
         S_WR_E: begin
            if (quiet) begin
               data_drive_nx = 1'b0;
               rn_w_nx       = 1'b1;
               src_nx        = src_q + 32'd4;
               dst_nx        = dst_q + 32'd4;
               rem_nx        = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  bgack_nx = 1'b0;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
                  state_nx = S_RELEASE;
               end else begin
                  addr_nx  = src_q + 32'd4;
                  as_nx    = 1'b1;
                  ds_nx    = 1'b1;
                  tmr_nx   = TMR_LOAD;
                  state_nx = S_RD_S;
               end
            end
         end
         S_ABORT: begin
            if (quiet) begin
               bgack_nx      = 1'b0;
               busy_nx       = 1'b0;
               done_nx       = 1'b1;
               rn_w_nx       = 1'b1;
               data_drive_nx = 1'b0;
               state_nx      = S_RELEASE;
            end
         end
         S_RELEASE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         rem_q        <= '0;
         hold_q       <= '0;
         tmr_q        <= '0;
         addr_q       <= '0;
         data_out_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         br_q         <= 1'b0;
         bgack_q      <= 1'b0;
         data_drive_q <= 1'b0;
         as_q         <= 1'b0;
         ds_q         <= 1'b0;
         rn_w_q       <= 1'b1;
      end else begin
         state_q      <= state_nx;
         src_q        <= src_nx;
         dst_q        <= dst_nx;
         rem_q        <= rem_nx;
         hold_q       <= hold_nx;
         tmr_q        <= tmr_nx;
         addr_q       <= addr_nx;
         data_out_q   <= data_out_nx;
         busy_q       <= busy_nx;
         done_q       <= done_nx;
         error_q      <= error_nx;
         br_q         <= br_nx;
         bgack_q      <= bgack_nx;
         data_drive_q <= data_drive_nx;
         as_q         <= as_nx;
         ds_q         <= ds_nx;
         rn_w_q       <= rn_w_nx;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign br         = br_q;
   assign bgack      = bgack_q;
   assign bus_drive  = bgack_q;
   assign data_drive = data_drive_q;
   assign addr       = addr_q;
   assign data_out   = data_out_q;
   assign as         = as_q;
   assign ds         = ds_q;
   assign rn_w       = rn_w_q;
   assign siz        = 2'b00;
   assign fc         = bgack_q ? FC_CODE : 3'b000;

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: behavioural responder memory, arbiter and bus-rule monitor,
// with each transfer checked against the expected list of longword writes.
module tb_dma_bus_master;

   localparam int unsigned TMO = 8;
   localparam logic [2:0]  FC  = 3'b101;

   logic        clock, reset, start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] count;
   logic        busy, done, error, br, bgack, bus_drive, data_drive, as, ds, rn_w;
   logic [31:0] addr, data_out, data_in;
   logic [1:0]  siz, dsack;
   logic [2:0]  fc;
   logic        bg, bus_busy, berr;

   dma_bus_master #(.TIMEOUT(TMO), .FC_CODE(FC)) dut (
      .clock(clock), .reset(reset), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .count(count), .busy(busy), .done(done), .error(error),
      .br(br), .bg(bg), .bus_busy(bus_busy), .bgack(bgack), .bus_drive(bus_drive),
      .data_drive(data_drive), .addr(addr), .data_in(data_in), .data_out(data_out),
      .as(as), .ds(ds), .rn_w(rn_w), .siz(siz), .fc(fc), .dsack(dsack), .berr(berr)
   );

   int total, bad;
   int resp_min, resp_max, fail_at, fail_kind;
   bit auto_grant, manual_bg;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] wr_a_q[$], wr_d_q[$];
   int rd_cnt;
   int done_cnt, viol_cnt, br_cnt, cur_len, last_len;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // bus arbiter: grants as soon as asked unless a test drives bg by hand
   initial begin
      bg = 1'b0;
      forever begin
         @(posedge clock); #1;
         bg = auto_grant ? br : manual_bg;
      end
   end

   // longword responder: memory reads, write capture, injected faults on a chosen read
   initial begin
      logic        rd_l;
      logic [31:0] a_l;
      int          d_l, g_l;
      dsack = 2'b00; berr = 1'b0; data_in = '0; rd_cnt = 0;
      forever begin
         @(posedge clock); #1;
         if (as && !reset) begin
            rd_l = rn_w; a_l = addr;
            d_l = $urandom_range(resp_max, resp_min);
            repeat (d_l) begin @(posedge clock); #1; end
            if (as) begin
               if (rd_l) begin
                  if (rd_cnt == fail_at) begin
                     case (fail_kind)
                        1: berr = 1'b1;
                        3: dsack = 2'b01;
                        4: begin berr = 1'b1; dsack = 2'b11; data_in = mem_rd(a_l); end
                        default: ;
                     endcase
                  end else begin
                     data_in = mem_rd(a_l);
                     dsack = 2'b11;
                  end
                  rd_cnt++;
               end else begin
                  wr_a_q.push_back(a_l);
                  wr_d_q.push_back(data_out);
                  dsack = 2'b11;
               end
               g_l = 0;
               while (as && g_l < 64) begin @(posedge clock); #1; g_l++; end
               dsack = 2'b00; berr = 1'b0;
            end
         end
      end
   end

   // bus-rule monitor
   initial begin
      logic bgack_prev;
      done_cnt = 0; viol_cnt = 0; br_cnt = 0; cur_len = 0; last_len = 0; bgack_prev = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (done) done_cnt++;
         if (br) br_cnt++;
         if (as) cur_len++;
         else if (cur_len != 0) begin last_len = cur_len; cur_len = 0; end
         if (!reset) begin
            if (siz !== 2'b00 || addr[1:0] !== 2'b00 || bus_drive !== bgack ||
                fc !== (bgack ? FC : 3'b000) || (as && !bgack) || ds !== as ||
                (data_drive && rn_w) || (bgack_prev && !bgack && berr))
               viol_cnt++;
         end
         bgack_prev = bgack;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      src_addr = s; dst_addr = d; count = n; start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic do_transfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                              input int fidx, input int kind,
                              output bit ok, output int wbase, output int nwr, output int ndone);
      int dc0;
      fail_at   = (fidx >= 0) ? rd_cnt + fidx : -1;
      fail_kind = kind;
      wbase     = wr_a_q.size();
      dc0       = done_cnt;
      pulse_start(s, d, n);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (done) begin ok = 1'b1; break; end
         tick(1);
      end
      tick(4);
      nwr   = wr_a_q.size() - wbase;
      ndone = done_cnt - dc0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; bus_busy = 1'b0;
      src_addr = '0; dst_addr = '0; count = '0;
      tick(3);
      total++;
      if ({busy, done, error, br, bgack, bus_drive, data_drive, as, ds} !== 9'b0) begin
         bad++; $display("FAIL reset_ctl: got %b want 000000000",
                         {busy, done, error, br, bgack, bus_drive, data_drive, as, ds});
      end
      total++;
      if (rn_w !== 1'b1 || fc !== 3'b000 || siz !== 2'b00) begin
         bad++; $display("FAIL reset_rnw_fc: got rn_w=%b fc=%b siz=%b want 1 000 00", rn_w, fc, siz);
      end
      total++;
      if (addr !== 32'h0 || data_out !== 32'h0) begin
         bad++; $display("FAIL reset_addr_data: got %h %h want 0 0", addr, data_out);
      end
      reset = 1'b0;
      tick(3);
   endtask

   task automatic test_basic();
      bit ok; int wb, nwr, nd;
      mem[32'h0000_1000] = 32'h1122_3344;
      mem[32'h0000_1004] = 32'h5566_7788;
      resp_min = 3; resp_max = 3;
      do_transfer(32'h0000_1000, 32'h0000_2000, 16'd2, -1, 0, ok, wb, nwr, nd);
      total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout: got no done want done"); end
      total++; if (nwr != 2) begin bad++; $display("FAIL basic_nwr: got %0d want 2", nwr); end
      if (nwr == 2) begin
         total++;
         if (wr_a_q[wb] !== 32'h2000 || wr_d_q[wb] !== 32'h1122_3344) begin
            bad++; $display("FAIL basic_wr0: got %h=%h want 00002000=11223344", wr_a_q[wb], wr_d_q[wb]);
         end
         total++;
         if (wr_a_q[wb+1] !== 32'h2004 || wr_d_q[wb+1] !== 32'h5566_7788) begin
            bad++; $display("FAIL basic_wr1: got %h=%h want 00002004=55667788", wr_a_q[wb+1], wr_d_q[wb+1]);
         end
      end
      total++; if (nd != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", nd); end
      total++;
      if (error !== 1'b0 || br !== 1'b0 || bgack !== 1'b0 || bus_drive !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_end: got err=%b br=%b bgack=%b bd=%b busy=%b want 0",
                         error, br, bgack, bus_drive, busy);
      end
   endtask

   task automatic test_berr();
      bit ok; int wb, nwr, nd, v0;
      resp_min = 0; resp_max = 3; v0 = viol_cnt;
      do_transfer(32'h0000_3000, 32'h0000_6000, 16'd4, 1, 1, ok, wb, nwr, nd);
      total++; if (!ok) begin bad++; $display("FAIL berr_done_timeout: got no done want done"); end
      total++; if (nwr != 1) begin bad++; $display("FAIL berr_nwr: got %0d want 1", nwr); end
      if (nwr == 1) begin
         total++;
         if (wr_a_q[wb] !== 32'h6000 || wr_d_q[wb] !== mem_rd(32'h3000)) begin
            bad++; $display("FAIL berr_wr0: got %h=%h want 00006000=%h", wr_a_q[wb], wr_d_q[wb], mem_rd(32'h3000));
         end
      end
      total++; if (error !== 1'b1) begin bad++; $display("FAIL berr_error: got %b want 1", error); end
      total++; if (nd != 1) begin bad++; $display("FAIL berr_done_cnt: got %0d want 1", nd); end
      total++; if (viol_cnt != v0) begin bad++; $display("FAIL berr_bus_rules: got %0d want %0d", viol_cnt, v0); end
      total++; if (bgack !== 1'b0 || as !== 1'b0) begin bad++; $display("FAIL berr_release: got bgack=%b as=%b want 0 0", bgack, as); end
   endtask

   task automatic test_zero_count();
      int bc0;
      total++; if (error !== 1'b1) begin bad++; $display("FAIL zero_prev_error: got %b want 1", error); end
      bc0 = br_cnt;
      pulse_start(32'h0000_1000, 32'h0000_2000, 16'd0);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
         bad++; $display("FAIL zero_pulse: got done=%b busy=%b err=%b want 1 0 0", done, busy, error);
      end
      tick(1);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b want 0", done); end
      tick(8);
      total++; if (br_cnt != bc0) begin bad++; $display("FAIL zero_br: got %0d want %0d", br_cnt, bc0); end
   endtask

   task automatic test_timeout();
      bit ok; int wb, nwr, nd;
      resp_min = 0; resp_max = 3;
      do_transfer(32'h0000_7000, 32'h0000_7800, 16'd1, 0, 2, ok, wb, nwr, nd);
      total++; if (!ok) begin bad++; $display("FAIL tmo_done_timeout: got no done want done"); end
      total++; if (last_len != int'(TMO)) begin bad++; $display("FAIL tmo_strobe_len: got %0d want %0d", last_len, TMO); end
      total++; if (error !== 1'b1 || nwr != 0) begin bad++; $display("FAIL tmo_error: got err=%b nwr=%0d want 1 0", error, nwr); end
      total++; if (bgack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL tmo_release: got bgack=%b busy=%b want 0 0", bgack, busy); end
   endtask

   task automatic test_arbitration();
      bit early; int c, wb, nd0;
      auto_grant = 1'b0; manual_bg = 1'b0; bus_busy = 1'b0;
      resp_min = 0; resp_max = 2; fail_at = -1; fail_kind = 0;
      wb = wr_a_q.size(); nd0 = done_cnt;
      pulse_start(32'h0000_A000, 32'h0000_B000, 16'd1);
      early = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (i == 20) begin manual_bg = 1'b1; bus_busy = 1'b1; end
         if (!br || as || bgack) early = 1'b1;
         tick(1);
      end
      total++; if (early) begin bad++; $display("FAIL arb_hold: got early grant or br drop want br held"); end
      bus_busy = 1'b0;
      c = 0;
      while (!bgack && c < 10) begin tick(1); c++; end
      total++;
      if (!bgack || c < 2) begin bad++; $display("FAIL arb_grant: got bgack=%b after %0d clocks want 1 after >=2", bgack, c); end
      manual_bg = 1'b0;
      c = 0;
      while (!done && c < 500) begin tick(1); c++; end
      tick(4);
      auto_grant = 1'b1;
      total++;
      if (wr_a_q.size() - wb != 1 || done_cnt - nd0 != 1 || error !== 1'b0) begin
         bad++; $display("FAIL arb_xfer: got nwr=%0d ndone=%0d err=%b want 1 1 0", wr_a_q.size() - wb, done_cnt - nd0, error);
      end else begin
         total++;
         if (wr_a_q[wb] !== 32'h0000_B000 || wr_d_q[wb] !== mem_rd(32'h0000_A000)) begin
            bad++; $display("FAIL arb_wr0: got %h=%h want 0000b000=%h", wr_a_q[wb], wr_d_q[wb], mem_rd(32'h0000_A000));
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok; int c, wb, nwr, nd;
      resp_min = 3; resp_max = 3; fail_at = -1; fail_kind = 0;
      pulse_start(32'h0000_4000, 32'h0000_5000, 16'd3);
      c = 0;
      while (!(as && !rn_w) && c < 500) begin tick(1); c++; end
      total++; if (c >= 500) begin bad++; $display("FAIL rst_reach_wr: got no write strobe want write strobe"); end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({as, ds, bgack, bus_drive, data_drive, busy} !== 6'b0) begin
         bad++; $display("FAIL rst_async_drop: got %b want 000000", {as, ds, bgack, bus_drive, data_drive, busy});
      end
      tick(3);
      reset = 1'b0;
      tick(6);
      resp_min = 0; resp_max = 3;
      do_transfer(32'hFFFF_FFFC, 32'h0000_8000, 16'd2, -1, 0, ok, wb, nwr, nd);
      total++; if (!ok || nd != 1) begin bad++; $display("FAIL wrap_done: got ok=%b ndone=%0d want 1 1", ok, nd); end
      total++; if (nwr != 2 || error !== 1'b0) begin bad++; $display("FAIL wrap_nwr: got %0d err=%b want 2 0", nwr, error); end
      if (nwr == 2) begin
         total++;
         if (wr_d_q[wb] !== mem_rd(32'hFFFF_FFFC) || wr_d_q[wb+1] !== mem_rd(32'h0) ||
             wr_a_q[wb] !== 32'h8000 || wr_a_q[wb+1] !== 32'h8004) begin
            bad++; $display("FAIL wrap_data: got %h=%h %h=%h want 00008000=%h 00008004=%h",
                            wr_a_q[wb], wr_d_q[wb], wr_a_q[wb+1], wr_d_q[wb+1], mem_rd(32'hFFFF_FFFC), mem_rd(32'h0));
         end
      end
   endtask

   task automatic test_random();
      bit ok; int wb, nwr, nd, n, fidx, kind, r, nexp;
      logic [31:0] s, d, ea, ed;
      bit eerr;
      resp_min = 0; resp_max = 3;
      for (int it = 0; it < 10; it++) begin
         s = $urandom; d = $urandom;
         n = $urandom_range(6, 1);
         r = $urandom_range(9, 0);
         if (r < 6) begin kind = 0; fidx = -1; end
         else begin kind = r - 5; fidx = $urandom_range(n - 1, 0); end
         eerr = (fidx >= 0);
         nexp = eerr ? fidx : n;
         do_transfer(s, d, 16'(n), fidx, kind, ok, wb, nwr, nd);
         total++;
         if (!ok || nd != 1) begin bad++; $display("FAIL rnd%0d_done: got ok=%b ndone=%0d want 1 1", it, ok, nd); end
         total++;
         if (error !== eerr) begin bad++; $display("FAIL rnd%0d_error: got %b want %b (kind %0d)", it, error, eerr, kind); end
         total++;
         if (nwr != nexp) begin bad++; $display("FAIL rnd%0d_nwr: got %0d want %0d", it, nwr, nexp); end
         for (int i = 0; i < nexp && i < nwr; i++) begin
            ea = {d[31:2], 2'b00} + 32'(4 * i);
            ed = mem_rd({s[31:2], 2'b00} + 32'(4 * i));
            total++;
            if (wr_a_q[wb+i] !== ea || wr_d_q[wb+i] !== ed) begin
               bad++; $display("FAIL rnd%0d_wr%0d: got %h=%h want %h=%h", it, i, wr_a_q[wb+i], wr_d_q[wb+i], ea, ed);
            end
         end
         total++;
         if (bgack !== 1'b0 || br !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rnd%0d_end: got bgack=%b br=%b busy=%b want 0", it, bgack, br, busy);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      auto_grant = 1'b1; manual_bg = 1'b0;
      resp_min = 0; resp_max = 3; fail_at = -1; fail_kind = 0;
      test_reset();
      test_basic();
      test_berr();
      test_zero_count();
      test_timeout();
      test_arbitration();
      test_reset_mid();
      test_random();
      total++;
      if (viol_cnt != 0) begin bad++; $display("FAIL bus_rules: got %0d violations want 0", viol_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dma_bus_master.md
Name: dma_bus_master

Overview:
- 68030-style bus initiator for the MAXI030 glue logic: a single-channel longword block-copy DMA engine.
- Requests the bus with the BR/BG/BGACK handshake, then runs asynchronous read and write cycles (AS, DS, R/W, SIZ, FC) terminated by DSACK or BERR, the mirror image of the core's responder decode.
- Moves `count` longwords from `src_addr` to `dst_addr`, then releases the bus and signals done or error.
- All ports use positive logic; pad inversion and tristate buffers live at the top level.

Parameters:
- TIMEOUT, 255, clocks to wait in a strobe state for DSACK/BERR before aborting with error.
- FC_CODE, 3'b101, function code driven during DMA cycles (supervisor data).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-clock pulse; launches transfer when idle.
- src_addr  in  32  source byte address; bits 1:0 ignored.
- dst_addr  in  32  destination byte address; bits 1:0 ignored.
- count  in  16  number of longwords to copy.
- busy  out  1  high from accepted start until done.
- done  out  1  one-clock pulse at completion (success or error).
- error  out  1  sticky status of last transfer; cleared on next accepted start.
- br  out  1  bus request.
- bg  in  1  bus grant (asynchronous).
- bus_busy  in  1  another master's AS asserted (asynchronous).
- bgack  out  1  bus grant acknowledge; high while this block owns the bus.
- bus_drive  out  1  enables board drivers for addr/as/ds/rn_w/siz/fc; equals bgack.
- data_drive  out  1  enables data output buffers; write cycles only.
- addr  out  32  bus address; bits 1:0 always 00.
- data_in  in  32  bus data (read path).
- data_out  out  32  bus data (write path).
- as  out  1  address strobe.
- ds  out  1  data strobe.
- rn_w  out  1  1 = read, 0 = write.
- siz  out  2  always 2'b00 (longword).
- fc  out  3  FC_CODE while bus_drive, else 000.
- dsack  in  2  data strobe acknowledge, positive logic (asynchronous).
- berr  in  1  bus error, positive logic (asynchronous).

Behaviour:
- Reset (async): state IDLE; busy, done, error, br, bgack, bus_drive, data_drive, as, ds = 0; rn_w = 1; addr, data_out, internal counters = 0. Reset mid-cycle drops strobes and the bus immediately.
- bg, bus_busy, dsack, berr pass through 2-flop synchronisers; every "sees" below refers to the synchronised value.
- start while busy: ignored. start with count = 0: done pulses next clock, busy stays 0, error = 0, br is never raised.
- States and transitions:
  - IDLE: on accepted start, latch src/dst/count, clear error, busy = 1, go to REQ.
  - REQ: br = 1. When bg = 1 and bus_busy = 0, go to GRANT.
  - GRANT: bgack = 1, br = 0, bus_drive = 1; drive addr = src. Go to RD_S.
  - RD_S: rn_w = 1, as = 1, ds = 1; timeout counter runs.
    - dsack == 11: latch data_in into the holding register; go to RD_E.
    - berr, any other nonzero dsack (port-size mismatch), or timeout: set error; go to ABORT.
  - RD_E: as = ds = 0. Wait until dsack == 00 and berr == 0, then drive addr = dst, rn_w = 0, data_out = held data, data_drive = 1. Go to WR_A.
  - WR_A: one clock of address/data setup. Go to WR_S.
  - WR_S: as = 1, ds = 1. Termination and error rules are the same as RD_S.
  - WR_E: as = ds = 0. After dsack/berr negate: data_drive = 0, rn_w = 1, src += 4, dst += 4, remaining -= 1.
    - remaining == 0: go to RELEASE.
    - otherwise: drive addr = src, go to RD_S.
  - ABORT: as = ds = 0, data_drive = 0. Wait for dsack/berr to negate, then go to RELEASE.
  - RELEASE: bgack = 0, bus_drive = 0, busy = 0, done = 1 for one clock. Go to IDLE.
- Address arithmetic: 32-bit, wraps from FFFFFFFC to 00000000 with no error.
- bg deasserting after GRANT has no effect; the block keeps the bus until RELEASE (bgack holds it).
- dsack and berr asserted together in a strobe state: berr wins, error set.
- Timeout counter reloads on entry to RD_S and WR_S. With TIMEOUT = N, abort occurs on the Nth clock without termination.

Test Plan:
- count = 2, src = 00001000, dst = 00002000, responder returns DSACK = 11 after 3 clocks with data 11223344 then 55667788 -> two read/write pairs; writes to 00002000 and 00002004 carry those values; done pulses once; error = 0; br, bgack, bus_drive end at 0.
- start with count = 0 -> done pulses the next clock; br never asserts; busy stays 0.
- BERR asserted on the second read of a count = 4 transfer -> AS/DS negate; only one write occurs; bgack drops after BERR negates; error = 1 with done.
- TIMEOUT = 8, no DSACK on a read -> abort after 8 strobe clocks; error = 1; bus released.
- bg held low for 20 clocks, then bus_busy high for 5 more clocks while bg = 1 -> br stays 1 throughout; as stays 0; GRANT is entered only after bus_busy falls.
- reset asserted during WR_S -> as, ds, bgack, data_drive drop asynchronously; busy = 0; a new start afterwards completes normally with src = FFFFFFFC, count = 2 (second address 00000000).
